// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the byte-serial threshold-implementation AES controller.
// Holds the controller state encoding, the per-state byte count and the
// round-constant seed and reduction polynomial, plus the GF(2^8) doubling
// helper used by the round-constant generator.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_MIXCOL,
        ST_UNLOAD
    } ctrl_state_e;

    localparam int unsigned BYTES_PER_STATE = 16;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the AES key schedule.
// Ports:
//   ClkxCI  - clock
//   RstxBI  - asynchronous active-low reset (register returns to RCON_INIT)
//   init    - reload RCON_INIT on the next edge (has priority over advance)
//   advance - replace the register with xtime(register) on the next edge
//   rcon    - current round constant
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       init,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            rcon_q <= RCON_INIT;
        end else if (init) begin
            rcon_q <= RCON_INIT;
        end else if (advance) begin
            rcon_q <= xtime(rcon_q);
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_ctrl_fsm.sv
// Sequencer for the byte-serial threshold-implementation AES datapath.
// Walks IDLE -> LOAD -> (ROUND -> MIXCOL) x NUM_ROUNDS -> UNLOAD -> IDLE and
// drives the share state-register controls, the state input mux select and
// the key-schedule byte/round/Rcon indices.
// Optional feature: define AES_CTRL_ABORT_EN to add AbortxSI, which returns
// any busy state to IDLE on the next edge with counters and Rcon reset.
// Ports:
//   ClkxCI, RstxBI  - clock, asynchronous active-low reset
//   StartxSI        - start request, taken only while ReadyxSO=1
//   AbortxSI        - (AES_CTRL_ABORT_EN only) abort the running operation
//   ReadyxSO        - idle, a start will be accepted
//   InSelxSO        - state input mux: 0 load/unload, 1 S-box output
//   ShiftRowsxSO    - ShiftRows strobe, last byte of each ROUND phase
//   MixColumnsxSO   - MixColumns enable during MIXCOL
//   NineRoundxSO    - high throughout the final round (ROUND and MIXCOL)
//   ByteCntxDO      - byte index within the current phase
//   RoundxDO        - round index 0..NUM_ROUNDS-1
//   RconxDO         - round constant for the key schedule
//   OutValidxSO     - ciphertext byte valid during UNLOAD
//   DonexSO         - single-cycle pulse on the last ciphertext byte
module aes_ctrl_fsm
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned MC_CYCLES  = 4
) (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       StartxSI,
`ifdef AES_CTRL_ABORT_EN
    input  logic       AbortxSI,
`endif
    output logic       ReadyxSO,
    output logic       InSelxSO,
    output logic       ShiftRowsxSO,
    output logic       MixColumnsxSO,
    output logic       NineRoundxSO,
    output logic [3:0] ByteCntxDO,
    output logic [3:0] RoundxDO,
    output logic [7:0] RconxDO,
    output logic       OutValidxSO,
    output logic       DonexSO
);

    localparam logic [3:0] LAST_BYTE  = 4'(BYTES_PER_STATE - 1);
    localparam logic [3:0] LAST_MC    = 4'(MC_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    ctrl_state_e state_q, state_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [3:0]  round_q, round_nxt;
    logic        rcon_init, rcon_adv;
    logic        abort;

    logic ready_q, insel_q, sr_q, mc_q, nine_q, ov_q, done_q;
    logic ready_d, insel_d, sr_d, mc_d, nine_d, ov_d, done_d;

`ifdef AES_CTRL_ABORT_EN
    assign abort = AbortxSI;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            round_q <= round_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        round_nxt = round_q;
        rcon_init = 1'b0;
        rcon_adv  = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            round_nxt = '0;
            rcon_init = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (StartxSI) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = '0;
                        round_nxt = '0;
                        rcon_init = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == LAST_BYTE) begin
                        state_nxt = ST_ROUND;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (cnt_q == LAST_BYTE) begin
                        state_nxt = ST_MIXCOL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                end
                ST_MIXCOL: begin
                    if (cnt_q == LAST_MC) begin
                        cnt_nxt = '0;
                        if (round_q < LAST_ROUND) begin
                            state_nxt = ST_ROUND;
                            round_nxt = round_q + 4'd1;
                            rcon_adv  = 1'b1;
                        end else begin
                            state_nxt = ST_UNLOAD;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    // Leaving UNLOAD restores the counters and Rcon so that
                    // IDLE always presents the reset values.
                    if (cnt_q == LAST_BYTE) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        round_nxt = '0;
                        rcon_init = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    round_nxt = '0;
                    rcon_init = 1'b1;
                end
            endcase
        end
    end

    // Control outputs are decoded from the next state/counters and registered,
    // so they align with state_q/cnt_q and carry no combinational path from
    // StartxSI.
    always_comb begin
        ready_d = (state_nxt == ST_IDLE);
        insel_d = (state_nxt == ST_ROUND) || (state_nxt == ST_MIXCOL);
        sr_d    = (state_nxt == ST_ROUND) && (cnt_nxt == LAST_BYTE);
        mc_d    = (state_nxt == ST_MIXCOL);
        nine_d  = ((state_nxt == ST_ROUND) || (state_nxt == ST_MIXCOL))
                  && (round_nxt == LAST_ROUND);
        ov_d    = (state_nxt == ST_UNLOAD);
        done_d  = (state_nxt == ST_UNLOAD) && (cnt_nxt == LAST_BYTE);
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            ready_q <= 1'b1;
            insel_q <= 1'b0;
            sr_q    <= 1'b0;
            mc_q    <= 1'b0;
            nine_q  <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            insel_q <= insel_d;
            sr_q    <= sr_d;
            mc_q    <= mc_d;
            nine_q  <= nine_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    aes_rcon_gen u_rcon (
        .ClkxCI  (ClkxCI),
        .RstxBI  (RstxBI),
        .init    (rcon_init),
        .advance (rcon_adv),
        .rcon    (RconxDO)
    );

    assign ReadyxSO      = ready_q;
    assign InSelxSO      = insel_q;
    assign ShiftRowsxSO  = sr_q;
    assign MixColumnsxSO = mc_q;
    assign NineRoundxSO  = nine_q;
    assign ByteCntxDO    = cnt_q;
    assign RoundxDO      = round_q;
    assign OutValidxSO   = ov_q;
    assign DonexSO       = done_q;

endmodule
